// File: rtl/detect_pkg.sv
// -----------------------------------------------------------------------------
// detect_pkg
// Shared definitions for the serial bit-pattern detector path.
//
// Contents:
//   DEF_DATA_W / DEF_PAT_W / DEF_CNT_W : default widths used by the modules
//   state_t                            : frame controller FSM states
//   RST_STATE                          : state entered on reset
//   RST_BIT                            : reset value of single-bit registers
//   fill_width()                       : bits needed to count 0..n inclusive
// -----------------------------------------------------------------------------
package detect_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_PAT_W  = 4;
   localparam int DEF_CNT_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_BIT   = 1'b0;

   // The fill counter must be able to hold the value n itself, not just n-1.
   function automatic int fill_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pattern_shift_match.sv
// -----------------------------------------------------------------------------
// pattern_shift_match
// Shift-register history plus maskable compare against a target pattern.
//
// Parameters:
//   PAT_W   : history / pattern length in bits (>= 2)
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   clr     in   synchronous clear of history and fill counter
//   en      in   a new serial bit is present on din this cycle
//   din     in   serial bit, shifted into history bit 0 (newest)
//   pattern in   target pattern, bit PAT_W-1 oldest, bit 0 newest
//   mask    in   per-bit compare enable (0 = don't care)
//   match   out  combinational: the bit on din completes a match this cycle
//   hit     out  registered version of match (one cycle later)
// -----------------------------------------------------------------------------
module pattern_shift_match
   import detect_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   input  logic [PAT_W-1:0] mask,
   output logic             match,
   output logic             hit
);

   localparam int FILL_W = fill_width(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist_q;
   logic [PAT_W-1:0]  hist_next;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_next;

   // Next history and fill level. History only moves when a bit arrives, so
   // gaps in the serial stream leave it untouched. The fill counter stops at
   // PAT_W and gates the compare, which keeps the all-zero reset history from
   // matching an all-zero (or fully masked) pattern before enough real bits
   // have been seen.
   always_comb begin
      hist_next = hist_q;
      fill_next = fill_q;
      if (en) begin
         hist_next = {hist_q[PAT_W-2:0], din};
         if (fill_q != FILL_FULL) begin
            fill_next = fill_q + FILL_W'(1);
         end
      end
   end

   // Compare on the post-shift history so the match belongs to the bit that
   // is arriving now; the registered hit then trails that bit by one cycle.
   assign match = en && (fill_next == FILL_FULL) &&
                  (((hist_next ^ pattern) & mask) == '0);

   // History, fill level and hit pulse registers.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist_q <= '0;
         fill_q <= '0;
         hit    <= RST_BIT;
      end else begin
         hist_q <= hist_next;
         fill_q <= fill_next;
         hit    <= match;
      end
   end

endmodule

// File: rtl/detect_seq_ctrl.sv
// -----------------------------------------------------------------------------
// detect_seq_ctrl
// Frame-level controller for the serial bit-pattern detector. Accepts words
// over valid/ready, serialises them MSB-first, runs the bits through
// pattern_shift_match, counts overlapping matches per frame, raises a sticky
// threshold interrupt and pulses done at frame end.
//
// Parameters:
//   DATA_W : input word width (bits shifted per accepted word)
//   PAT_W  : pattern / history length (>= 2)
//   CNT_W  : hit counter and threshold width
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a frame (only honoured in IDLE)
//   cfg_pattern  in   target pattern (bit PAT_W-1 oldest)
//   cfg_mask     in   per-bit compare enable
//   cfg_thresh   in   hit count that raises irq, 0 disables irq
//   s_valid      in   input word valid
//   s_data       in   input word
//   s_last       in   word is last of the frame
//   s_ready      out  controller can take a word (LOAD only)
//   bit_out      out  current serial bit
//   bit_valid    out  bit_out carries a bit this cycle
//   hit          out  one-cycle match pulse
//   hit_count    out  saturating hit count for the current frame
//   irq          out  sticky threshold interrupt
//   busy         out  not IDLE
//   done         out  one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module detect_seq_ctrl
   import detect_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PAT_W  = DEF_PAT_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic [PAT_W-1:0]  cfg_mask,
   input  logic [CNT_W-1:0]  cfg_thresh,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              hit,
   output logic [CNT_W-1:0]  hit_count,
   output logic              irq,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   state_t            state_q;
   state_t            state_next;

   logic [DATA_W-1:0] sreg_q;
   logic [IDX_W-1:0]  idx_q;
   logic              last_q;

   logic [PAT_W-1:0]  pat_q;
   logic [PAT_W-1:0]  mask_q;
   logic [CNT_W-1:0]  thresh_q;

   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_inc;
   logic              irq_q;

   logic              start_ok;
   logic              accept;
   logic              shifting;
   logic              word_end;
   logic              arm_clr;
   logic              match_now;
   logic              hit_reg;

   assign start_ok = (state_q == ST_IDLE) && start;
   assign accept   = (state_q == ST_LOAD) && s_valid;
   assign shifting = (state_q == ST_SHIFT);
   assign word_end = shifting && (idx_q == IDX_LAST);
   assign arm_clr  = (state_q == ST_ARM);

   // Saturating increment so a long frame parks at all-ones instead of
   // wrapping back below the threshold.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
      end else begin
         state_q <= state_next;
      end
   end

   // Next-state and Moore outputs. LOAD always costs at least one cycle per
   // word, so consecutive words are separated by a bit_valid=0 cycle; the
   // matcher simply holds its history through it.
   always_comb begin
      state_next = state_q;
      s_ready    = 1'b0;
      bit_valid  = 1'b0;
      bit_out    = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = ST_ARM;
            end
         end
         ST_ARM: begin
            state_next = ST_LOAD;
         end
         ST_LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bit_valid = 1'b1;
            bit_out   = sreg_q[DATA_W-1];
            if (word_end) begin
               state_next = last_q ? ST_DONE : ST_LOAD;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Serialiser: the word is captured on the handshake, then shifted left so
   // the MSB always sits at the output tap.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q <= '0;
         idx_q  <= '0;
         last_q <= RST_BIT;
      end else if (accept) begin
         sreg_q <= s_data;
         idx_q  <= '0;
         last_q <= s_last;
      end else if (shifting) begin
         sreg_q <= sreg_q << 1;
         idx_q  <= idx_q + IDX_W'(1);
      end
   end

   // Configuration is latched once per frame so the producer may change the
   // cfg_* inputs freely while a frame is running.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q    <= '0;
         mask_q   <= '0;
         thresh_q <= '0;
      end else if (start_ok) begin
         pat_q    <= cfg_pattern;
         mask_q   <= cfg_mask;
         thresh_q <= cfg_thresh;
      end
   end

   // Hit counter and sticky interrupt. Counting uses the matcher's
   // combinational match so the count updates on the same edge the hit pulse
   // rises; both results then hold through DONE and IDLE until the next start.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         irq_q <= RST_BIT;
      end else if (start_ok) begin
         cnt_q <= '0;
         irq_q <= 1'b0;
      end else if (match_now) begin
         cnt_q <= cnt_inc;
         if ((thresh_q != '0) && (cnt_inc == thresh_q)) begin
            irq_q <= 1'b1;
         end
      end
   end

   pattern_shift_match #(
      .PAT_W (PAT_W)
   ) u_match (
      .clk     (clk),
      .rst     (rst),
      .clr     (arm_clr),
      .en      (shifting),
      .din     (sreg_q[DATA_W-1]),
      .pattern (pat_q),
      .mask    (mask_q),
      .match   (match_now),
      .hit     (hit_reg)
   );

   assign hit       = hit_reg;
   assign hit_count = cnt_q;
   assign irq       = irq_q;

endmodule
